mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_priority.sv | 48 ++++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the fetch/data memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

    // Counter width able to hold 0..limit inclusive.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/arb_priority.sv
// rtl/arb_priority.sv - data-first priority select with fetch starvation guard
module arb_priority
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic if_valid_i,
    input  logic d_valid_i,
    output logic grant_if,
    output logic grant_d
);

    localparam int unsigned       CW    = cnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0]     LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt_q;
    logic [CW-1:0] starve_cnt_d;
    logic          fetch_forced;

    assign fetch_forced = if_valid_i && (starve_cnt_q == LIMIT);

    always_comb begin
        grant_d  = en_i && d_valid_i && !fetch_forced;
        grant_if = en_i && if_valid_i && !grant_d;
    end

    // Counts data grants that overtook a waiting fetch; any gap in fetch demand forgives the debt.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_valid_i || grant_if) begin
            starve_cnt_d = '0;
        end else if (grant_d && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port memory between fetch and data paths
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_data
);

    arb_state_e        state_q;
    arb_owner_e        owner_q;
    logic              owner_we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              if_rsp_valid_q;
    logic              d_rsp_valid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic can_grant;
    logic grant_if;
    logic grant_d;
    logic any_grant;

    assign can_grant = !rst && ((state_q == IDLE) || (state_q == RESP));
    assign any_grant = grant_if || grant_d;

    arb_priority #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_priority (
        .clk       (clk),
        .rst       (rst),
        .en_i      (can_grant),
        .if_valid_i(if_req_valid),
        .d_valid_i (d_req_valid),
        .grant_if  (grant_if),
        .grant_d   (grant_d)
    );

    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;

    // The memory samples the address in the grant cycle, so the winner is forwarded straight through.
    always_comb begin
        mem_address      = addr_q;
        mem_write_data   = wdata_q;
        mem_write_enable = 1'b0;
        if (grant_d) begin
            mem_address      = d_addr;
            mem_write_data   = d_wdata;
            mem_write_enable = d_we;
        end else if (grant_if) begin
            mem_address      = if_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= OWN_IF;
            owner_we_q     <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            if_rsp_valid_q <= 1'b0;
            d_rsp_valid_q  <= 1'b0;
            if_rdata_q     <= '0;
            d_rdata_q      <= '0;
        end else begin
            if_rsp_valid_q <= 1'b0;
            d_rsp_valid_q  <= 1'b0;
            if (any_grant) begin
                addr_q     <= mem_address;
                wdata_q    <= mem_write_data;
                owner_q    <= grant_d ? OWN_D : OWN_IF;
                owner_we_q <= grant_d && d_we;
            end
            case (state_q)
                IDLE: begin
                    if (any_grant) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (owner_q == OWN_D) begin
                        d_rsp_valid_q <= 1'b1;
                        d_rdata_q     <= owner_we_q ? '0 : mem_read_data;
                    end else begin
                        if_rsp_valid_q <= 1'b1;
                        if_rdata_q     <= mem_read_data;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    state_q <= any_grant ? WAIT : IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_rsp_valid = if_rsp_valid_q;
    assign d_rsp_valid  = d_rsp_valid_q;
    assign if_rdata     = if_rdata_q;
    assign d_rdata      = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [31:0] if_addr = '0;
    logic        if_rsp_valid;
    logic [31:0] if_rdata;
    logic        d_req_valid = 1'b0;
    logic        d_req_ready;
    logic [31:0] d_addr = '0;
    logic        d_we = 1'b0;
    logic [31:0] d_wdata = '0;
    logic        d_rsp_valid;
    logic [31:0] d_rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Single-port memory device: read data appears the cycle after the address.
    logic [31:0] dev_mem [logic [31:0]];
    always @(posedge clk) begin
        mem_read_data <= dev_mem.exists(mem_address) ? dev_mem[mem_address] : dflt(mem_address);
        if (mem_write_enable) dev_mem[mem_address] = mem_write_data;
    end

    // Reference model: one access occupies two cycles, response two cycles after grant.
    logic [31:0] model_mem [logic [31:0]];
    int          next_grant = 0;
    int          rsp_cyc    = -1;
    bit          rsp_is_d   = 1'b0;
    logic [31:0] rsp_data   = '0;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_d_rdata  = '0;
    logic [31:0] last_addr  = '0;
    logic [31:0] last_wdata = '0;
    int          streak     = 0;
    bit          m_can, m_gi, m_gd;
    logic [31:0] e_addr, e_wdata;
    bit          e_we;

    always @(negedge clk) begin
        if (rst) begin
            next_grant = 0; rsp_cyc = -1; streak = 0;
            exp_if_rdata = '0; exp_d_rdata = '0; last_addr = '0; last_wdata = '0;
            check("rst_if_ready", if_req_ready, 0);
            check("rst_d_ready", d_req_ready, 0);
            check("rst_if_rsp", if_rsp_valid, 0);
            check("rst_d_rsp", d_rsp_valid, 0);
            check("rst_mem_we", mem_write_enable, 0);
            check("rst_mem_addr", mem_address, 0);
            check("rst_if_rdata", if_rdata, 0);
            check("rst_d_rdata", d_rdata, 0);
        end else begin
            if (rsp_cyc == cyc) begin
                if (rsp_is_d) exp_d_rdata = rsp_data;
                else          exp_if_rdata = rsp_data;
            end
            check("if_rsp_valid", if_rsp_valid, (rsp_cyc == cyc) && !rsp_is_d);
            check("d_rsp_valid", d_rsp_valid, (rsp_cyc == cyc) && rsp_is_d);
            check("if_rdata", if_rdata, exp_if_rdata);
            check("d_rdata", d_rdata, exp_d_rdata);

            m_can = (cyc >= next_grant);
            m_gd  = m_can && d_req_valid && !(streak == LIM && if_req_valid);
            m_gi  = m_can && if_req_valid && !m_gd;
            check("if_req_ready", if_req_ready, m_gi);
            check("d_req_ready", d_req_ready, m_gd);

            e_addr = last_addr; e_wdata = last_wdata; e_we = 1'b0;
            if (m_gd) begin
                e_addr = d_addr; e_wdata = d_wdata; e_we = d_we;
            end else if (m_gi) begin
                e_addr = if_addr;
            end
            check("mem_address", mem_address, e_addr);
            check("mem_write_data", mem_write_data, e_wdata);
            check("mem_write_enable", mem_write_enable, e_we);

            if (m_gd || m_gi) begin
                last_addr = e_addr; last_wdata = e_wdata;
                next_grant = cyc + 2; rsp_cyc = cyc + 2; rsp_is_d = m_gd;
                if (e_we) begin
                    rsp_data = '0;
                    model_mem[e_addr] = e_wdata;
                end else begin
                    rsp_data = model_mem.exists(e_addr) ? model_mem[e_addr] : dflt(e_addr);
                end
            end
            if (!if_req_valid || m_gi) streak = 0;
            else if (m_gd && streak < LIM) streak++;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, holds it until accepted, then withdraws it (returns in the WAIT cycle).
    task automatic req(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        bit got = 1'b0;
        if (is_d) begin
            d_req_valid = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req_valid = 1'b1; if_addr = addr;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (is_d ? d_req_ready : if_req_ready) begin
                got = 1'b1;
                check("grant_addr", mem_address, addr);
                check("grant_we", mem_write_enable, is_d && we);
                if (is_d && we) check("grant_wdata", mem_write_data, wdata);
            end
        end
        if (!got) begin
            compared++; mismatched++;
            $display("FAIL grant_timeout: no ready for addr %h", addr);
        end
        step();
        if (is_d) d_req_valid = 1'b0;
        else      if_req_valid = 1'b0;
    endtask

    int seq [10];
    int exp_seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int ng;

    initial begin
        dev_mem[32'h10]    = 32'h0050_0093; model_mem[32'h10]  = 32'h0050_0093;
        dev_mem[32'h20]    = 32'h0000_0013; model_mem[32'h20]  = 32'h0000_0013;
        dev_mem[32'h100]   = 32'h1234_5678; model_mem[32'h100] = 32'h1234_5678;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_if_ready", if_req_ready, 0);
        check("idle_d_ready", d_req_ready, 0);
        check("idle_mem_addr", mem_address, 0);
        step();

        // Lone fetch
        req(1'b0, 1'b0, 32'h10, '0);
        @(negedge clk); check("fetch_t1_rsp", if_rsp_valid, 0);
        @(negedge clk);
        check("fetch_t2_rsp", if_rsp_valid, 1);
        check("fetch_t2_rdata", if_rdata, 32'h0050_0093);
        check("fetch_t2_d_rsp", d_rsp_valid, 0);
        step(); step();

        // Simultaneous fetch and data read
        if_req_valid = 1'b1; if_addr = 32'h20;
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        @(negedge clk);
        check("sim_t0_d_ready", d_req_ready, 1);
        check("sim_t0_if_ready", if_req_ready, 0);
        step(); d_req_valid = 1'b0;
        @(negedge clk); check("sim_t1_if_ready", if_req_ready, 0);
        @(negedge clk);
        check("sim_t2_d_rsp", d_rsp_valid, 1);
        check("sim_t2_d_rdata", d_rdata, 32'h1234_5678);
        check("sim_t2_if_ready", if_req_ready, 1);
        step(); if_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("sim_t4_if_rsp", if_rsp_valid, 1);
        check("sim_t4_if_rdata", if_rdata, 32'h0000_0013);
        check("sim_t4_d_rsp", d_rsp_valid, 0);
        step();

        // Write then read back
        req(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
        @(negedge clk); check("wr_t1_we", mem_write_enable, 0);
        @(negedge clk);
        check("wr_t2_rsp", d_rsp_valid, 1);
        check("wr_t2_rdata", d_rdata, 0);
        step();
        req(1'b1, 1'b0, 32'h100, '0);
        @(negedge clk); @(negedge clk);
        check("rdback_rdata", d_rdata, 32'hDEAD_BEEF);
        step(); step();

        // Starvation: data always valid, fetch re-requests immediately after each grant
        if_req_valid = 1'b1; if_addr = 32'h30;
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        ng = 0;
        for (int i = 0; i < 40 && ng < 10; i++) begin
            @(negedge clk);
            if (d_req_ready)  begin seq[ng] = 1; ng++; end
            if (if_req_ready) begin seq[ng] = 0; ng++; end
            step();
            if (ng > 0 && seq[ng-1] == 1) d_addr = d_addr + 32'd4;
            if (ng > 0 && seq[ng-1] == 0) if_addr = if_addr + 32'd4;
        end
        d_req_valid = 1'b0; if_req_valid = 1'b0;
        check("starve_grants", ng, 10);
        for (int i = 0; i < 10; i++) check($sformatf("starve_seq%0d", i), seq[i], exp_seq[i]);
        step(); step(); step();

        // Sustained fetches: back-to-back grants every other cycle
        for (int i = 0; i < 3; i++) req(1'b0, 1'b0, 32'h40 + 32'(i * 4), '0);
        step(); step();

        // Reset during WAIT aborts the access
        req(1'b0, 1'b0, 32'h10, '0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_if_rsp", if_rsp_valid, 0);
        end
        step(); rst = 1'b0;
        req(1'b0, 1'b0, 32'h10, '0);
        @(negedge clk); @(negedge clk);
        check("post_rst_rsp", if_rsp_valid, 1);
        check("post_rst_rdata", if_rdata, 32'h0050_0093);
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
